// File: rtl/turf_command_transmitter_pkg.sv
// Shared TURF->SURF command-link definitions: state encoding, bit timing
// defaults and frame framing, used by the transmitter and receiver models.
package turf_command_transmitter_pkg;

  localparam int NCLOCK_BITS_DEF = 3;
  localparam int NGAP_BITS_DEF   = 4;
  localparam int FRAME_BITS      = 36;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_BUF0   = 3'd2;
  localparam logic [2:0] ST_BUF1   = 3'd3;
  localparam logic [2:0] ST_SHIFT  = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;
  localparam logic [2:0] ST_GAP    = 3'd6;

  typedef struct packed {
    logic [1:0]  buffer;
    logic [31:0] event_id;
  } cmd_frame_t;

endpackage

// File: rtl/turf_command_transmitter_bit_timer.sv
// Bit-period counter for the command link; wraps every 2^NCLOCK_BITS clocks
// and is held at zero while the link is idle.
module cmd_bit_timer #(
  parameter int NCLOCK_BITS = 3
) (
  input  logic                   clk33_i,
  input  logic                   rst_n_i,
  input  logic                   clear,
  output logic [NCLOCK_BITS-1:0] bit_cnt,
  output logic                   bit_wrap
);

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i)   bit_cnt <= '0;
    else if (clear) bit_cnt <= '0;
    else            bit_cnt <= bit_cnt + NCLOCK_BITS'(1);
  end

  assign bit_wrap = !clear && (&bit_cnt);

endmodule

// File: rtl/turf_command_transmitter.sv
// Serialises one TURF command frame (start, 2 buffer bits, 32-bit event ID
// LSB first, stop) onto a registered line, followed by an idle-low gap.
//
// state    | meaning
// IDLE     | line low, waiting for req_i
// START    | start bit (1)
// BUF0     | buffer bit 0
// BUF1     | buffer bit 1
// SHIFT    | 32 event ID bits, LSB first
// STOP     | stop bit (0)
// GAP      | idle-low gap before the next frame
module turf_command_transmitter
  import turf_command_transmitter_pkg::*;
#(
  parameter int NCLOCK_BITS = NCLOCK_BITS_DEF,
  parameter int NGAP_BITS   = NGAP_BITS_DEF
) (
  input  logic        clk33_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic [1:0]  buffer_i,
  input  logic [31:0] event_id_i,
  output logic        ack_o,
  output logic        busy_o,
  output logic        cmd_o,
  output logic [15:0] frame_count_o
);

  localparam int GAP_W = (NGAP_BITS > 1) ? $clog2(NGAP_BITS) : 1;
  localparam logic [GAP_W-1:0]       GAP_LAST = GAP_W'(NGAP_BITS - 1);
  localparam logic [NCLOCK_BITS-1:0] BIT_PRE  = NCLOCK_BITS'((1 << NCLOCK_BITS) - 2);

  logic [2:0]             state;
  logic [31:0]            shift_reg;
  logic [1:0]             buf_bits;
  logic [4:0]             shift_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [15:0]            frame_cnt;
  logic                   cmd_q;
  logic                   ack_q;
  logic [NCLOCK_BITS-1:0] bit_cnt;
  logic                   bit_wrap;
  logic                   gap_done;

  cmd_bit_timer #(.NCLOCK_BITS(NCLOCK_BITS)) u_bit_timer (
    .clk33_i  (clk33_i),
    .rst_n_i  (rst_n_i),
    .clear    (state == ST_IDLE),
    .bit_cnt  (bit_cnt),
    .bit_wrap (bit_wrap)
  );

  // GAP leaves one clock early: the single IDLE cycle that follows completes
  // the last gap period, so a held request restarts exactly on the boundary.
  assign gap_done = (state == ST_GAP) && (gap_cnt == GAP_LAST) && (bit_cnt == BIT_PRE);

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      buf_bits  <= '0;
      shift_cnt <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      cmd_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            state     <= ST_START;
            shift_reg <= event_id_i;
            buf_bits  <= buffer_i;
            shift_cnt <= '0;
            ack_q     <= 1'b1;
            cmd_q     <= START_BIT;
          end
        end
        ST_START: if (bit_wrap) begin
          state <= ST_BUF0;
          cmd_q <= buf_bits[0];
        end
        ST_BUF0: if (bit_wrap) begin
          state <= ST_BUF1;
          cmd_q <= buf_bits[1];
        end
        ST_BUF1: if (bit_wrap) begin
          state <= ST_SHIFT;
          cmd_q <= shift_reg[0];
        end
        ST_SHIFT: if (bit_wrap) begin
          shift_cnt <= shift_cnt + 5'd1;
          shift_reg <= shift_reg >> 1;
          if (&shift_cnt) begin
            state <= ST_STOP;
            cmd_q <= STOP_BIT;
          end else begin
            cmd_q <= shift_reg[1];
          end
        end
        ST_STOP: if (bit_wrap) begin
          state   <= ST_GAP;
          gap_cnt <= '0;
          cmd_q   <= 1'b0;
        end
        ST_GAP: begin
          if (gap_done) begin
            state     <= ST_IDLE;
            frame_cnt <= frame_cnt + 16'd1;
          end else if (bit_wrap) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cmd_q <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o         = ack_q;
  assign busy_o        = (state != ST_IDLE);
  assign cmd_o         = cmd_q;
  assign frame_count_o = frame_cnt;

endmodule

// File: tb/tb_turf_command_transmitter.sv
// Directed bench for turf_command_transmitter: cycle-exact frame check,
// back-to-back frames, delayed loopback receiver, reset truncation, count wrap.
module tb_turf_command_transmitter;

  logic        clk33_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_i = 1'b0;
  logic [1:0]  buffer_i = '0;
  logic [31:0] event_id_i = '0;
  logic        ack_o;
  logic        busy_o;
  logic        cmd_o;
  logic [15:0] frame_count_o;

  turf_command_transmitter dut (
    .clk33_i       (clk33_i),
    .rst_n_i       (rst_n_i),
    .req_i         (req_i),
    .buffer_i      (buffer_i),
    .event_id_i    (event_id_i),
    .ack_o         (ack_o),
    .busy_o        (busy_o),
    .cmd_o         (cmd_o),
    .frame_count_o (frame_count_o)
  );

  always #15 clk33_i = ~clk33_i;

  logic [3:0] cmd_pipe = '0;
  always @(posedge clk33_i) cmd_pipe <= {cmd_pipe[2:0], cmd_o};

  typedef struct packed {
    logic [1:0]  b;
    logic [31:0] ev;
  } frm_t;
  frm_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic tick;
    @(posedge clk33_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [1:0] b, input logic [31:0] ev, input int i);
    if (i == 0) return 1'b1;
    if (i == 1) return b[0];
    if (i == 2) return b[1];
    if (i <= 34) return ev[i-3];
    return 1'b0;
  endfunction

  function automatic logic line_of(input int d);
    if (d == 0) return cmd_o;
    return cmd_pipe[d-1];
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 400) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy_o}, 32'd0);
  endtask

  // Receiver: find the start bit, then sample each bit near its centre.
  task automatic rx_frame(input int d, output logic ok, output logic [1:0] b,
                          output logic [31:0] ev);
    int n;
    logic [35:0] bits;
    ok = 1'b0; b = '0; ev = '0; bits = '0;
    n = 0;
    while (!line_of(d) && n < 600) begin
      tick();
      n++;
    end
    if (!line_of(d)) return;
    for (int k = 0; k < 4; k++) tick();
    bits[0] = line_of(d);
    for (int i = 1; i < 36; i++) begin
      for (int k = 0; k < 8; k++) tick();
      bits[i] = line_of(d);
    end
    b  = bits[2:1];
    ev = bits[34:3];
    ok = bits[0] && !bits[35];
  endtask

  initial begin
    logic [1:0]  cap_b;
    logic [31:0] cap_ev;
    int          ack_cyc[3];
    int          n_ack;
    int          highs;
    logic        ok;
    logic [1:0]  rb;
    logic [31:0] rev;
    frm_t        exp_f;

    // Reset state
    tick();
    chk("rst_cmd", {31'd0, cmd_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_count", {16'd0, frame_count_o}, 32'd0);
    tick();
    rst_n_i = 1'b1;
    tick();

    // Reset at cycle 100 of a frame truncates it
    req_i = 1'b1; buffer_i = 2'b01; event_id_i = 32'h1234_5678;
    tick();
    req_i = 1'b0;
    chk("mid_ack", {31'd0, ack_o}, 32'd1);
    for (int c = 2; c <= 100; c++) tick();
    chk("mid_cmd_pre", {31'd0, cmd_o}, 32'd1);
    chk("mid_busy_pre", {31'd0, busy_o}, 32'd1);
    rst_n_i = 1'b0;
    #1;
    chk("mid_cmd_rst", {31'd0, cmd_o}, 32'd0);
    chk("mid_busy_rst", {31'd0, busy_o}, 32'd0);
    chk("mid_count_rst", {16'd0, frame_count_o}, 32'd0);
    tick(); tick();
    rst_n_i = 1'b1;
    highs = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (cmd_o || busy_o) highs++;
    end
    chk("mid_no_resume", highs, 32'd0);

    // Cycle-exact frame, inputs scrambled every cycle after acceptance
    cap_b = 2'b10; cap_ev = 32'hA5A5_0001;
    req_i = 1'b1; buffer_i = cap_b; event_id_i = cap_ev;
    tick();
    req_i = 1'b0;
    for (int c = 1; c <= 321; c++) begin
      chk($sformatf("cmd_c%0d", c), {31'd0, cmd_o},
          {31'd0, (((c-1)/8) < 36) ? frame_bit(cap_b, cap_ev, (c-1)/8) : 1'b0});
      if (c == 1)   chk("ack_c1", {31'd0, ack_o}, 32'd1);
      if (c == 2)   chk("ack_c2", {31'd0, ack_o}, 32'd0);
      if (c == 318) chk("busy_c318", {31'd0, busy_o}, 32'd1);
      if (c == 321) begin
        chk("busy_c321", {31'd0, busy_o}, 32'd0);
        chk("count_1", {16'd0, frame_count_o}, 32'd1);
      end
      event_id_i = $urandom;
      buffer_i   = 2'($urandom_range(0, 3));
      tick();
    end

    // Held request: three back-to-back frames
    buffer_i = 2'b00; event_id_i = 32'h0;
    req_i = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 1100 && n_ack < 3; c++) begin
      tick();
      if (ack_o) begin
        ack_cyc[n_ack] = c;
        n_ack++;
      end
    end
    req_i = 1'b0;
    chk("b2b_acks", n_ack, 32'd3);
    if (n_ack == 3) begin
      chk("b2b_space1", ack_cyc[1] - ack_cyc[0], 32'd320);
      chk("b2b_space2", ack_cyc[2] - ack_cyc[1], 32'd320);
    end
    wait_idle("b2b_idle");
    chk("b2b_count", {16'd0, frame_count_o}, 32'd4);

    // Loopback through 0-3 cycles of line delay
    for (int d = 0; d < 4; d++) begin
      sb_q.push_back('{b: 2'b11, ev: 32'hDEAD_BEEF});
      req_i = 1'b1; buffer_i = 2'b11; event_id_i = 32'hDEAD_BEEF;
      tick();
      req_i = 1'b0; buffer_i = 2'b00; event_id_i = 32'h0;
      rx_frame(d, ok, rb, rev);
      chk($sformatf("lb%0d_sb", d), sb_q.size(), 32'd1);
      if (sb_q.size() > 0) begin
        exp_f = sb_q.pop_front();
        chk($sformatf("lb%0d_digitize", d), {31'd0, ok}, 32'd1);
        chk($sformatf("lb%0d_buffer", d), {30'd0, rb}, {30'd0, exp_f.b});
        chk($sformatf("lb%0d_event", d), rev, exp_f.ev);
      end
      wait_idle($sformatf("lb%0d_idle", d));
      for (int k = 0; k < 6; k++) tick();
    end
    chk("lb_count", {16'd0, frame_count_o}, 32'd8);

    // Frame counter wraps from 0xFFFF
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    tick();
    chk("wrap_preset", {16'd0, frame_count_o}, 32'h0000_FFFF);
    req_i = 1'b1; buffer_i = 2'b01; event_id_i = 32'h0F0F_0F0F;
    tick();
    req_i = 1'b0;
    wait_idle("wrap_idle");
    chk("wrap_count", {16'd0, frame_count_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
